program_sequencer: RTL and testbench

//  Run controller that sits in front of TopLevel and launches P1, P2, P3 back to back.
//  For each program it pulses CoreStart with that program's start PC and waits for the core's Ack.
//  It measures the run length in cycles and reports one result per program, then raises AllDone.
//  A watchdog aborts the sequence when a program exceeds its cycle budget.

---
 rtl/program_sequencer_if.sv | 26 ++
 rtl/program_sequencer.sv | 120 ++++++++++++
 tb/tb_program_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_sequencer_if.sv
// Handshake bundle between the run controller, its host (Go/results) and the core (Start/Ack).
interface program_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             Go;
  logic             CoreAck;
  logic             CoreStart;
  logic [PC_W-1:0]  StartPC;
  logic [1:0]       ProgIdx;
  logic             Busy;
  logic             ResultValid;
  logic [CNT_W-1:0] CycleCount;
  logic             AllDone;
  logic             Timeout;

  modport master (
    input  Go, CoreAck,
    output CoreStart, StartPC, ProgIdx, Busy, ResultValid, CycleCount, AllDone, Timeout
  );

  modport slave (
    output Go, CoreAck,
    input  CoreStart, StartPC, ProgIdx, Busy, ResultValid, CycleCount, AllDone, Timeout
  );
endinterface

// File: rtl/program_sequencer.sv
// Launches NUM_PROGS programs on the core back to back, times each run and reports it;
// a per-program watchdog aborts the sequence when a run exceeds TIMEOUT_CYC cycles.
module program_sequencer #(
  parameter int NUM_PROGS   = 3,
  parameter int PC_W        = 10,
  parameter int CNT_W       = 16,
  parameter int START_CYC   = 2,
  parameter int PROG0_PC    = 0,
  parameter int PROG1_PC    = 0,
  parameter int PROG2_PC    = 0,
  parameter int PROG3_PC    = 0,
  parameter int TIMEOUT_CYC = 60000
) (
  input logic                 Clk,
  input logic                 Reset,
  program_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, REPORT, DONE, ABORT} state_t;

  localparam int               LW      = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [LW-1:0]    L_LAST  = LW'(START_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT_CYC);
  localparam logic [1:0]       P_LAST  = 2'(NUM_PROGS - 1);

  state_t           state;
  logic [LW-1:0]    lcnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             armed;
  logic [1:0]       idx;
  logic             done_hit;

  assign cnt_nxt  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  // armed is registered, so an Ack seen in the same cycle that arms cannot complete
  assign done_hit = armed && bus.CoreAck;
  assign bus.ProgIdx = idx;

  // idx only moves on the REPORT->LAUNCH edge, so this decode is stable while Busy
  always_comb begin
    bus.StartPC = PC_W'(PROG0_PC);
    case (idx)
      2'd0: bus.StartPC = PC_W'(PROG0_PC);
      2'd1: bus.StartPC = PC_W'(PROG1_PC);
      2'd2: bus.StartPC = PC_W'(PROG2_PC);
      2'd3: bus.StartPC = PC_W'(PROG3_PC);
      default: bus.StartPC = PC_W'(PROG0_PC);
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state           <= IDLE;
      lcnt            <= '0;
      cnt             <= '0;
      armed           <= 1'b0;
      idx             <= '0;
      bus.CoreStart   <= 1'b0;
      bus.Busy        <= 1'b0;
      bus.ResultValid <= 1'b0;
      bus.CycleCount  <= '0;
      bus.AllDone     <= 1'b0;
      bus.Timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ABORT: begin
          if (bus.Go) begin
            state         <= LAUNCH;
            idx           <= '0;
            lcnt          <= '0;
            bus.AllDone   <= 1'b0;
            bus.Timeout   <= 1'b0;
            bus.Busy      <= 1'b1;
            bus.CoreStart <= 1'b1;
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          armed <= 1'b0;
          if (lcnt == L_LAST) begin
            bus.CoreStart <= 1'b0;
            state         <= RUN;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt_nxt;
          if (!armed && !bus.CoreAck) armed <= 1'b1;
          // completion is tested first so it wins over a same-cycle watchdog hit
          if (done_hit) begin
            state           <= REPORT;
            bus.ResultValid <= 1'b1;
            bus.CycleCount  <= cnt_nxt;
          end else if (cnt_nxt >= TMO) begin
            state       <= ABORT;
            bus.Timeout <= 1'b1;
            bus.Busy    <= 1'b0;
          end
        end
        REPORT: begin
          bus.ResultValid <= 1'b0;
          if (idx == P_LAST) begin
            state       <= DONE;
            bus.AllDone <= 1'b1;
            bus.Busy    <= 1'b0;
          end else begin
            idx           <= idx + 1'b1;
            lcnt          <= '0;
            bus.CoreStart <= 1'b1;
            state         <= LAUNCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Randomized and directed bench for program_sequencer; the bench acts as host and core,
// predicting each run's reported length from the Ack waveform it drives.
module tb_program_sequencer;
  localparam int PC_W = 10, CNT_W = 16, SC = 2, TMO = 100, WL = 160;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  program_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus();

  program_sequencer #(
    .NUM_PROGS(3), .PC_W(PC_W), .CNT_W(CNT_W), .START_CYC(SC),
    .PROG0_PC(0), .PROG1_PC(40), .PROG2_PC(120), .PROG3_PC(0), .TIMEOUT_CYC(TMO)
  ) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int tests = 0, fails = 0;
  int exp_pc[3] = '{0, 40, 120};

  // Ack waveform per program indexed by RUN cycle (1-based); stale_hi is the level held
  // during that program's REPORT/LAUNCH lead-in.
  bit ackw[3][WL];
  bit stale_hi[3];
  int go_mid = 0;

  int obs_n, obs_cnt[4], obs_idx[4], cs_len[3], pc_bad;
  int obs_idx_end, obs_runc_end, obs_first_idx;
  bit obs_done, obs_tmo, obs_busy_end, obs_first_cs, obs_first_alldone, obs_first_tmo;

  int exp_n, exp_cnt[3], exp_end_idx;
  bit exp_abort;

  task automatic set_wave(input int p, input int lead, input int d);
    for (int k = 0; k < WL; k++) ackw[p][k] = (k >= 1 && k <= lead) || (d > 0 && k >= d);
  endtask

  // Reference: a run finishes on the first RUN cycle with Ack high after Ack has been seen
  // low in that run; no such cycle within TMO cycles means abort.
  function automatic int ref_cnt(input int p);
    bit seen0 = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      if (ackw[p][k] && seen0) return k;
      if (!ackw[p][k]) seen0 = 1'b1;
    end
    return 0;
  endfunction

  task automatic build_expect();
    int c;
    exp_n = 0; exp_abort = 1'b0; exp_end_idx = 2;
    for (int p = 0; p < 3; p++) begin
      c = ref_cnt(p);
      if (c == 0) begin exp_abort = 1'b1; exp_end_idx = p; break; end
      exp_cnt[exp_n] = c; exp_n++;
    end
  endtask

  // Host+core engine: issues Go, plays the Ack waveforms and records what the DUT reports.
  task automatic run_seq();
    int runc = 0, budget, p;
    bit running = 1'b0, prev_cs = 1'b0;
    obs_n = 0; pc_bad = 0; cs_len = '{0, 0, 0};
    obs_done = 0; obs_tmo = 0; obs_busy_end = 1; obs_idx_end = -1; obs_runc_end = 0;
    @(negedge Clk);
    bus.Go = 1'b1; bus.CoreAck = stale_hi[0];
    @(negedge Clk);
    bus.Go = 1'b0;
    obs_first_cs = bus.CoreStart; obs_first_idx = bus.ProgIdx;
    obs_first_alldone = bus.AllDone; obs_first_tmo = bus.Timeout;
    for (budget = 0; budget < 600; budget++) begin
      if (budget > 0) @(negedge Clk);
      bus.Go = 1'b0;
      p = (bus.ProgIdx > 2) ? 2 : int'(bus.ProgIdx);
      if (bus.AllDone || bus.Timeout) begin
        obs_done = bus.AllDone; obs_tmo = bus.Timeout; obs_busy_end = bus.Busy;
        obs_idx_end = bus.ProgIdx; obs_runc_end = runc;
        break;
      end
      if (bus.CoreStart) begin
        running = 1'b0; cs_len[p]++;
        if (bus.StartPC !== exp_pc[p]) pc_bad++;
        bus.CoreAck = stale_hi[p];
      end else if (bus.ResultValid) begin
        if (obs_n < 4) begin obs_cnt[obs_n] = bus.CycleCount; obs_idx[obs_n] = bus.ProgIdx; end
        obs_n++; running = 1'b0;
        bus.CoreAck = (p < 2) ? stale_hi[p+1] : 1'b0;
      end else if (prev_cs || running) begin
        if (prev_cs) runc = 1;
        running = 1'b1;
        bus.CoreAck = ackw[p][(runc < WL) ? runc : WL-1];
        if (p == 0 && runc == go_mid) bus.Go = 1'b1;
        runc++;
      end else begin
        bus.CoreAck = 1'b0;
      end
      prev_cs = bus.CoreStart;
    end
    bus.CoreAck = 1'b0; bus.Go = 1'b0;
    tests++;
    if (budget >= 600) begin fails++; $display("FAIL seq_budget: sequence did not end, got %0d cycles want <600", budget); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    tests++;
    if ({bus.CoreStart, bus.Busy, bus.ResultValid, bus.AllDone, bus.Timeout, bus.ProgIdx, bus.CycleCount} !== '0) begin
      fails++; $display("FAIL reset_outs: got %b want all 0",
        {bus.CoreStart, bus.Busy, bus.ResultValid, bus.AllDone, bus.Timeout, bus.ProgIdx, bus.CycleCount});
    end
    tests++;
    if (bus.StartPC !== exp_pc[0]) begin fails++; $display("FAIL reset_pc: got %0d want %0d", bus.StartPC, exp_pc[0]); end
    @(negedge Clk); Reset = 1'b1;
  endtask

  task automatic test_reset_midrun();
    stale_hi = '{0, 0, 0};
    set_wave(0, 0, 20); set_wave(1, 0, 35); set_wave(2, 0, 50);
    @(negedge Clk); bus.Go = 1'b1;
    @(negedge Clk); bus.Go = 1'b0;
    repeat (6) @(negedge Clk);
    tests++;
    if (bus.Busy !== 1'b1) begin fails++; $display("FAIL midrun_busy: got %b want 1", bus.Busy); end
    #2 Reset = 1'b0;
    #1;
    tests++;
    if ({bus.CoreStart, bus.Busy, bus.ResultValid, bus.AllDone, bus.Timeout, bus.ProgIdx, bus.CycleCount} !== '0) begin
      fails++; $display("FAIL midrun_reset_outs: got %b want all 0",
        {bus.CoreStart, bus.Busy, bus.ResultValid, bus.AllDone, bus.Timeout, bus.ProgIdx, bus.CycleCount});
    end
    @(negedge Clk); Reset = 1'b1;
    run_seq();
    tests++;
    if (obs_first_cs !== 1'b1 || obs_first_idx != 0 || cs_len[0] != SC) begin
      fails++; $display("FAIL midrun_relaunch: got cs=%b idx=%0d len=%0d want cs=1 idx=0 len=%0d",
        obs_first_cs, obs_first_idx, cs_len[0], SC);
    end
    tests++;
    if (obs_n != 3 || obs_done !== 1'b1) begin fails++; $display("FAIL midrun_seq: got n=%0d done=%b want n=3 done=1", obs_n, obs_done); end
  endtask

  task automatic test_nominal();
    int want[3] = '{20, 35, 50};
    stale_hi = '{0, 0, 0};
    set_wave(0, 0, 20); set_wave(1, 0, 35); set_wave(2, 0, 50);
    run_seq();
    tests++;
    if (obs_n != 3) begin fails++; $display("FAIL nom_count: got %0d results want 3", obs_n); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (obs_cnt[i] != want[i] || obs_idx[i] != i) begin
        fails++; $display("FAIL nom_result%0d: got cnt=%0d idx=%0d want cnt=%0d idx=%0d", i, obs_cnt[i], obs_idx[i], want[i], i);
      end
    end
    tests++;
    if (obs_done !== 1'b1 || obs_tmo !== 1'b0 || obs_busy_end !== 1'b0) begin
      fails++; $display("FAIL nom_end: got done=%b tmo=%b busy=%b want 1 0 0", obs_done, obs_tmo, obs_busy_end);
    end
    tests++;
    if (cs_len[0] != SC || cs_len[1] != SC || cs_len[2] != SC || pc_bad != 0) begin
      fails++; $display("FAIL nom_start_pc: got len=%0d/%0d/%0d pc_bad=%0d want len=%0d each pc_bad=0",
        cs_len[0], cs_len[1], cs_len[2], pc_bad, SC);
    end
  endtask

  task automatic test_stale_ack();
    stale_hi = '{0, 1, 0};
    set_wave(0, 0, 20); set_wave(1, 2, 12); set_wave(2, 0, 50);
    run_seq();
    tests++;
    if (obs_n != 3 || obs_cnt[1] != 12 || obs_idx[1] != 1 || obs_cnt[0] != 20) begin
      fails++; $display("FAIL stale_ack: got n=%0d p1=%0d p2=%0d idx=%0d want n=3 p1=20 p2=12 idx=1",
        obs_n, obs_cnt[0], obs_cnt[1], obs_idx[1]);
    end
    stale_hi = '{0, 0, 0};
  endtask

  task automatic test_timeout();
    set_wave(0, 0, 10); set_wave(1, 0, 0); set_wave(2, 0, 30);
    run_seq();
    tests++;
    if (obs_n != 1 || obs_cnt[0] != 10) begin fails++; $display("FAIL tmo_results: got n=%0d cnt=%0d want n=1 cnt=10", obs_n, obs_cnt[0]); end
    tests++;
    if (obs_tmo !== 1'b1 || obs_done !== 1'b0 || obs_busy_end !== 1'b0 || obs_idx_end != 1) begin
      fails++; $display("FAIL tmo_flags: got tmo=%b done=%b busy=%b idx=%0d want 1 0 0 1", obs_tmo, obs_done, obs_busy_end, obs_idx_end);
    end
    tests++;
    if (obs_runc_end != TMO + 1) begin fails++; $display("FAIL tmo_len: got %0d RUN cycles want %0d", obs_runc_end - 1, TMO); end
    // Ack on the very cycle the watchdog would fire: the run must complete
    set_wave(0, 0, TMO); set_wave(1, 0, 5); set_wave(2, 0, 7);
    run_seq();
    tests++;
    if (obs_first_tmo !== 1'b0) begin fails++; $display("FAIL tmo_clear: got Timeout=%b after Go want 0", obs_first_tmo); end
    tests++;
    if (obs_n != 3 || obs_cnt[0] != TMO || obs_tmo !== 1'b0 || obs_done !== 1'b1) begin
      fails++; $display("FAIL tmo_edge: got n=%0d cnt=%0d tmo=%b done=%b want n=3 cnt=%0d tmo=0 done=1",
        obs_n, obs_cnt[0], obs_tmo, obs_done, TMO);
    end
  endtask

  task automatic test_go_busy();
    set_wave(0, 0, 15); set_wave(1, 0, 8); set_wave(2, 0, 22);
    go_mid = 5;
    run_seq();
    go_mid = 0;
    tests++;
    if (obs_n != 3 || obs_cnt[0] != 15 || obs_cnt[2] != 22 || obs_done !== 1'b1) begin
      fails++; $display("FAIL go_busy: got n=%0d p1=%0d p3=%0d done=%b want n=3 p1=15 p3=22 done=1",
        obs_n, obs_cnt[0], obs_cnt[2], obs_done);
    end
    run_seq();
    tests++;
    if (obs_first_cs !== 1'b1 || obs_first_idx != 0 || obs_first_alldone !== 1'b0) begin
      fails++; $display("FAIL go_restart: got cs=%b idx=%0d alldone=%b want cs=1 idx=0 alldone=0",
        obs_first_cs, obs_first_idx, obs_first_alldone);
    end
    tests++;
    if (obs_n != 3) begin fails++; $display("FAIL go_restart_n: got %0d results want 3", obs_n); end
  endtask

  task automatic test_random();
    int lead;
    for (int it = 0; it < 8; it++) begin
      for (int p = 0; p < 3; p++) begin
        lead = $urandom_range(0, 6);
        stale_hi[p] = (p > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int k = 0; k < WL; k++)
          ackw[p][k] = (k >= 1 && k <= lead) || (k > lead && $urandom_range(0, 15) == 0);
        if ($urandom_range(0, 11) == 0)
          for (int k = lead + 1; k < WL; k++) ackw[p][k] = 1'b0;
      end
      build_expect();
      run_seq();
      tests++;
      if (obs_n != exp_n || obs_tmo !== exp_abort || obs_done === exp_abort || obs_idx_end != exp_end_idx) begin
        fails++; $display("FAIL rand%0d_end: got n=%0d tmo=%b done=%b idx=%0d want n=%0d tmo=%b idx=%0d",
          it, obs_n, obs_tmo, obs_done, obs_idx_end, exp_n, exp_abort, exp_end_idx);
      end
      for (int i = 0; i < exp_n && i < obs_n; i++) begin
        tests++;
        if (obs_cnt[i] != exp_cnt[i] || obs_idx[i] != i) begin
          fails++; $display("FAIL rand%0d_res%0d: got cnt=%0d idx=%0d want cnt=%0d idx=%0d",
            it, i, obs_cnt[i], obs_idx[i], exp_cnt[i], i);
        end
      end
      tests++;
      if (pc_bad != 0) begin fails++; $display("FAIL rand%0d_pc: got %0d bad StartPC cycles want 0", it, pc_bad); end
    end
    stale_hi = '{0, 0, 0};
  endtask

  initial begin
    bus.Go = 1'b0;
    bus.CoreAck = 1'b0;
    test_reset();
    test_reset_midrun();
    test_nominal();
    test_stale_ack();
    test_timeout();
    test_go_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
